// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - control bundle between the CPU controller, instruction ROM, data memory and datapath
// master = controller side; slave = ROM/datapath/data-memory side.
interface cpu_controller_if #(
  parameter int PC_W = 8,
  parameter int DA_W = 8
);
  logic [15:0]     I_data;
  logic [15:0]     Rp_data;
  logic [PC_W-1:0] I_addr;
  logic            I_rd;
  logic [DA_W-1:0] D_addr;
  logic            D_rd;
  logic            D_wr;
  logic            RF_s;
  logic [3:0]      RF_W_addr;
  logic            RF_W_wr;
  logic [3:0]      RF_Rp_addr;
  logic            RF_Rp_rd;
  logic [3:0]      RF_Rq_addr;
  logic            RF_Rq_rd;
  logic            alu_s0;
  logic            halted;
  logic            illegal;

  modport master (
    input  I_data, Rp_data,
    output I_addr, I_rd, D_addr, D_rd, D_wr, RF_s, RF_W_addr, RF_W_wr,
           RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, alu_s0, halted, illegal
  );

  modport slave (
    output I_data, Rp_data,
    input  I_addr, I_rd, D_addr, D_rd, D_wr, RF_s, RF_W_addr, RF_W_wr,
           RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, alu_s0, halted, illegal
  );
endinterface

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - fetch/decode/execute control unit for the 16-bit single-cycle-datapath CPU
// Every instruction is FETCH, DECODE, execute; outputs are Moore-decoded from state and IR.
module cpu_controller #(
  parameter int PC_W = 8,
  parameter int DA_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  cpu_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_ADD,
    S_SUB,
    S_JMPZ,
    S_HALT
  } state_e;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      opcode;
  logic [3:0]      rd_f, rs_f, rt_f;
  logic [PC_W-1:0] off_ext;

  logic [PC_W-1:0] i_addr;
  logic            i_rd;
  logic [DA_W-1:0] d_addr;
  logic            d_rd, d_wr;
  logic            rf_s;
  logic [3:0]      rf_w_addr, rf_rp_addr, rf_rq_addr;
  logic            rf_w_wr, rf_rp_rd, rf_rq_rd;
  logic            alu_s0;
  logic            halted;

  assign opcode  = ir_q[15:12];
  assign rd_f    = ir_q[11:8];
  assign rs_f    = ir_q[7:4];
  assign rt_f    = ir_q[3:0];
  assign off_ext = PC_W'($signed(ir_q[7:0]));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_INIT;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    illegal_d  = illegal_q;
    i_addr     = '0;
    i_rd       = 1'b0;
    d_addr     = '0;
    d_rd       = 1'b0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_wr    = 1'b0;
    rf_rp_addr = '0;
    rf_rp_rd   = 1'b0;
    rf_rq_addr = '0;
    rf_rq_rd   = 1'b0;
    alu_s0     = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        i_addr  = pc_q;
        i_rd    = 1'b1;
        ir_d    = bus.I_data;
        pc_d    = pc_q + PC_ONE;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          4'h0:    state_d = S_LOAD;
          4'h1:    state_d = S_STORE;
          4'h2:    state_d = S_ADD;
          4'h3:    state_d = S_SUB;
          4'h5:    state_d = S_JMPZ;
          4'hF:    state_d = S_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_LOAD: begin
        d_addr    = ir_q[DA_W-1:0];
        d_rd      = 1'b1;
        rf_s      = 1'b1;
        rf_w_addr = rd_f;
        rf_w_wr   = 1'b1;
        state_d   = S_FETCH;
      end
      S_STORE: begin
        d_addr     = ir_q[DA_W-1:0];
        d_wr       = 1'b1;
        rf_rp_addr = rd_f;
        rf_rp_rd   = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADD, S_SUB: begin
        rf_rp_addr = rs_f;
        rf_rp_rd   = 1'b1;
        rf_rq_addr = rt_f;
        rf_rq_rd   = 1'b1;
        rf_w_addr  = rd_f;
        rf_w_wr    = 1'b1;
        alu_s0     = (state_q == S_SUB);
        state_d    = S_FETCH;
      end
      S_JMPZ: begin
        rf_rp_addr = rd_f;
        rf_rp_rd   = 1'b1;
        // pc_q already points past the JMPZ, so step back to its own address first
        if (bus.Rp_data == 16'h0000) pc_d = pc_q - PC_ONE + off_ext;
        state_d    = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

  assign bus.I_addr     = i_addr;
  assign bus.I_rd       = i_rd;
  assign bus.D_addr     = d_addr;
  assign bus.D_rd       = d_rd;
  assign bus.D_wr       = d_wr;
  assign bus.RF_s       = rf_s;
  assign bus.RF_W_addr  = rf_w_addr;
  assign bus.RF_W_wr    = rf_w_wr;
  assign bus.RF_Rp_addr = rf_rp_addr;
  assign bus.RF_Rp_rd   = rf_rp_rd;
  assign bus.RF_Rq_addr = rf_rq_addr;
  assign bus.RF_Rq_rd   = rf_rq_rd;
  assign bus.alu_s0     = alu_s0;
  assign bus.halted     = halted;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller with a behavioural ROM, register file and data memory
module tb_cpu_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_controller_if #(.PC_W(8), .DA_W(8)) bus ();
  cpu_controller #(.PC_W(8), .DA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] rom       [256];
  logic [15:0] dmem      [256];
  logic [15:0] dmem_init [256];
  logic [15:0] rf        [16];
  logic [15:0] rf_init   [16];

  assign bus.I_data  = rom[bus.I_addr];
  assign bus.Rp_data = rf[bus.RF_Rp_addr];

  // Datapath: reloads its initial contents while reset is held
  always @(posedge clk) begin
    if (!rst) begin
      rf   <= rf_init;
      dmem <= dmem_init;
    end else begin
      if (bus.RF_W_wr)
        rf[bus.RF_W_addr] <= bus.RF_s ? dmem[bus.D_addr] :
          (bus.alu_s0 ? rf[bus.RF_Rp_addr] - rf[bus.RF_Rq_addr]
                      : rf[bus.RF_Rp_addr] + rf[bus.RF_Rq_addr]);
      if (bus.D_wr) dmem[bus.D_addr] <= bus.Rp_data;
    end
  end

  wire [37:0] outs = {bus.I_addr, bus.I_rd, bus.D_addr, bus.D_rd, bus.D_wr, bus.RF_s,
                      bus.RF_W_addr, bus.RF_W_wr, bus.RF_Rp_addr, bus.RF_Rp_rd,
                      bus.RF_Rq_addr, bus.RF_Rq_rd, bus.alu_s0, bus.halted, bus.illegal};

  int n_vec = 0;
  int n_err = 0;
  int cyc, halt_idx, n_strobe;
  logic [7:0]  obs_fetch[$], exp_fetch[$];
  logic [23:0] obs_st[$], exp_st[$];
  logic        obs_alu[$], exp_alu[$];

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (bus.I_rd) obs_fetch.push_back(bus.I_addr);
    if (bus.D_wr) obs_st.push_back({bus.D_addr, bus.Rp_data});
    if (bus.RF_W_wr && !bus.RF_s) obs_alu.push_back(bus.alu_s0);
    if (bus.halted && halt_idx < 0) halt_idx = cyc;
    if (bus.D_rd | bus.D_wr | bus.RF_W_wr | bus.RF_Rp_rd | bus.RF_Rq_rd) n_strobe++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'hF000;
      dmem_init[i] = 16'h0000;
    end
    for (int i = 0; i < 16; i++) rf_init[i] = 16'h0000;
    exp_fetch.delete(); exp_st.delete(); exp_alu.delete();
  endtask

  // Leaves the DUT in its INIT cycle; the next step() lands on the first FETCH (cyc 0)
  task automatic launch();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    obs_fetch.delete(); obs_st.delete(); obs_alu.delete();
    cyc = -1; halt_idx = -1; n_strobe = 0;
  endtask

  task automatic run_to_halt(input int budget);
    for (int i = 0; i < budget && !bus.halted; i++) step();
  endtask

  task automatic test_reset();
    clear_mem();
    rom[0] = 16'h1109;
    rf_init[1] = 16'h00AA;
    launch();
    repeat (3) step();
    n_vec++; if (bus.D_wr !== 1'b1) begin n_err++; $display("FAIL reset_pre_store D_wr got %b want 1", bus.D_wr); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (outs !== 38'h0) begin n_err++; $display("FAIL reset_hold%0d outs got %h want 0", i, outs); end
    end
    rst = 1'b1;
    n_vec++; if (outs !== 38'h0) begin n_err++; $display("FAIL reset_init outs got %h want 0", outs); end
    step();
    n_vec++; if ({bus.I_rd, bus.I_addr} !== 9'h100) begin
      n_err++; $display("FAIL reset_first_fetch I_rd/I_addr got %h want 100", {bus.I_rd, bus.I_addr});
    end
  endtask

  task automatic test_load_add_store();
    clear_mem();
    rom[0] = 16'h0100; rom[1] = 16'h0201; rom[2] = 16'h2312; rom[3] = 16'h1309; rom[4] = 16'hF000;
    dmem_init[0] = 16'd5; dmem_init[1] = 16'd7;
    for (int i = 0; i < 5; i++) exp_fetch.push_back(8'(i));
    exp_st.push_back({8'd9, 16'd12});
    exp_alu.push_back(1'b0);
    launch();
    run_to_halt(40);
    n_vec++; if (halt_idx !== 14) begin n_err++; $display("FAIL prog_halt_cycle got %0d want 14", halt_idx); end
    n_vec++; if (obs_st.size() !== exp_st.size()) begin
      n_err++; $display("FAIL prog_store_count got %0d want %0d", obs_st.size(), exp_st.size());
    end
    while (exp_st.size() > 0 && obs_st.size() > 0) begin
      logic [23:0] e, o;
      e = exp_st.pop_front(); o = obs_st.pop_front();
      n_vec++; if (o !== e) begin n_err++; $display("FAIL prog_store addr/data got %h want %h", o, e); end
    end
    while (exp_fetch.size() > 0) begin
      logic [7:0] e, o;
      e = exp_fetch.pop_front();
      o = (obs_fetch.size() > 0) ? obs_fetch.pop_front() : 8'hxx;
      n_vec++; if (o !== e) begin n_err++; $display("FAIL prog_fetch I_addr got %h want %h", o, e); end
    end
    while (exp_alu.size() > 0) begin
      logic e, o;
      e = exp_alu.pop_front();
      o = (obs_alu.size() > 0) ? obs_alu.pop_front() : 1'bx;
      n_vec++; if (o !== e) begin n_err++; $display("FAIL prog_alu_s0 got %b want %b", o, e); end
    end
  endtask

  task automatic test_sub_wrap();
    clear_mem();
    rom[0] = 16'h0100; rom[1] = 16'h0201; rom[2] = 16'h3312; rom[3] = 16'h1309;
    dmem_init[0] = 16'd0; dmem_init[1] = 16'd1;
    exp_st.push_back({8'd9, 16'hFFFF});
    exp_alu.push_back(1'b1);
    launch();
    run_to_halt(40);
    n_vec++; if (!bus.halted) begin n_err++; $display("FAIL sub_halted got 0 want 1"); end
    while (exp_alu.size() > 0) begin
      logic e, o;
      e = exp_alu.pop_front();
      o = (obs_alu.size() > 0) ? obs_alu.pop_front() : 1'bx;
      n_vec++; if (o !== e) begin n_err++; $display("FAIL sub_alu_s0 got %b want %b", o, e); end
    end
    while (exp_st.size() > 0) begin
      logic [23:0] e, o;
      e = exp_st.pop_front();
      o = (obs_st.size() > 0) ? obs_st.pop_front() : 24'hxxxxxx;
      n_vec++; if (o !== e) begin n_err++; $display("FAIL sub_store addr/data got %h want %h", o, e); end
    end
  endtask

  task automatic test_jmpz();
    for (int taken = 1; taken >= 0; taken--) begin
      clear_mem();
      rom[0] = 16'h5004; rom[4] = 16'h51FE;
      rf_init[1] = taken ? 16'd0 : 16'd3;
      exp_fetch.push_back(8'd0); exp_fetch.push_back(8'd4);
      exp_fetch.push_back(taken ? 8'd2 : 8'd5);
      launch();
      run_to_halt(40);
      n_vec++; if (halt_idx !== 8) begin n_err++; $display("FAIL jmpz%0d_halt_cycle got %0d want 8", taken, halt_idx); end
      while (exp_fetch.size() > 0) begin
        logic [7:0] e, o;
        e = exp_fetch.pop_front();
        o = (obs_fetch.size() > 0) ? obs_fetch.pop_front() : 8'hxx;
        n_vec++; if (o !== e) begin n_err++; $display("FAIL jmpz%0d_fetch I_addr got %h want %h", taken, o, e); end
      end
    end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    rom[0] = 16'h50FF; rom[255] = 16'h2012; rom[1] = 16'hF000;
    rf_init[1] = 16'd1;
    exp_fetch.push_back(8'd0); exp_fetch.push_back(8'd255);
    exp_fetch.push_back(8'd0); exp_fetch.push_back(8'd1);
    launch();
    run_to_halt(40);
    n_vec++; if (obs_fetch.size() !== exp_fetch.size()) begin
      n_err++; $display("FAIL wrap_fetch_count got %0d want %0d", obs_fetch.size(), exp_fetch.size());
    end
    while (exp_fetch.size() > 0) begin
      logic [7:0] e, o;
      e = exp_fetch.pop_front();
      o = (obs_fetch.size() > 0) ? obs_fetch.pop_front() : 8'hxx;
      n_vec++; if (o !== e) begin n_err++; $display("FAIL wrap_fetch I_addr got %h want %h", o, e); end
    end
  endtask

  task automatic test_self_loop();
    clear_mem();
    rom[0] = 16'h5000;
    for (int i = 0; i < 4; i++) exp_fetch.push_back(8'd0);
    launch();
    repeat (12) step();
    n_vec++; if (obs_fetch.size() !== 4) begin
      n_err++; $display("FAIL selfloop_fetch_count got %0d want 4", obs_fetch.size());
    end
    while (exp_fetch.size() > 0) begin
      logic [7:0] e, o;
      e = exp_fetch.pop_front();
      o = (obs_fetch.size() > 0) ? obs_fetch.pop_front() : 8'hxx;
      n_vec++; if (o !== e) begin n_err++; $display("FAIL selfloop_fetch I_addr got %h want %h", o, e); end
    end
  endtask

  task automatic test_illegal();
    clear_mem();
    rom[0] = 16'h7000;
    launch();
    repeat (10) step();
    n_vec++; if (halt_idx !== 2) begin n_err++; $display("FAIL ill_halt_cycle got %0d want 2", halt_idx); end
    n_vec++; if ({bus.halted, bus.illegal} !== 2'b11) begin
      n_err++; $display("FAIL ill_flags halted/illegal got %b want 11", {bus.halted, bus.illegal});
    end
    n_vec++; if (n_strobe !== 0) begin n_err++; $display("FAIL ill_strobes got %0d want 0", n_strobe); end
    n_vec++; if (obs_fetch.size() !== 1) begin n_err++; $display("FAIL ill_fetch_count got %0d want 1", obs_fetch.size()); end
    rst = 1'b0;
    step();
    n_vec++; if ({bus.halted, bus.illegal} !== 2'b00) begin
      n_err++; $display("FAIL ill_clear halted/illegal got %b want 00", {bus.halted, bus.illegal});
    end
    rst = 1'b1;
  endtask

  initial begin
    clear_mem();
    cyc = 0; halt_idx = -1; n_strobe = 0;
    test_reset();
    test_load_add_store();
    test_sub_wrap();
    test_jmpz();
    test_pc_wrap();
    test_self_loop();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Control unit for the 16-bit single-cycle-datapath CPU: fetches 16-bit instructions, decodes them and drives every datapath control input (RF_s, RF_W_addr/wr, RF_Rp_addr/rd, RF_Rq_addr/rd, alu_s0) plus the data-memory address and strobes.
- Sits beside the datapath in the CPU top. Reads the instruction ROM directly and observes the datapath's Rp_data for conditional jumps.

Parameters:
- PC_W, 8, width of the program counter and instruction-memory address.
- DA_W, 8, width of the data-memory address. Must be ≤ 8, because addresses come from the IR[7:0] field.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-low
- I_data  input  16  instruction ROM read data, combinational from I_addr
- Rp_data  input  16  datapath read port P data, used for the JMPZ test
- I_addr  output  PC_W  instruction ROM address
- I_rd  output  1  instruction read strobe
- D_addr  output  DA_W  data-memory address
- D_rd  output  1  data-memory read strobe
- D_wr  output  1  data-memory write strobe; write data is the datapath Rp_data
- RF_s  output  1  write-back mux select: 1 = DM_Din, 0 = ALU result
- RF_W_addr  output  4  register-file write address
- RF_W_wr  output  1  register-file write enable
- RF_Rp_addr  output  4  read port P address
- RF_Rp_rd  output  1  read port P enable
- RF_Rq_addr  output  4  read port Q address
- RF_Rq_rd  output  1  read port Q enable
- alu_s0  output  1  ALU op select: 0 = add, 1 = subtract
- halted  output  1  high while in the HALT state
- illegal  output  1  sticky flag set by an undefined opcode

Behaviour:
- Registers: PC (PC_W bits), IR (16 bits), state, and the illegal flag.
- Reset: when rst==0 at a rising edge, the next state is INIT, PC=0, IR=0 and illegal=0.
  - All strobes and enables are 0, RF_s=0, alu_s0=0, and every address output is 0.
  - Reset wins over any state, including mid-instruction.
  - A store interrupted by reset never asserts D_wr after that edge.
- Outputs are Moore-decoded from state and IR. Every output not listed for a state is 0.
- ISA, opcode in IR[15:12], d = IR[11:8]:
  - 0000 LOAD d,a: RF[d] ← D[a], where a = IR[7:0].
  - 0001 STORE d,a: D[a] ← RF[d].
  - 0010 ADD d,s,t: RF[d] ← RF[s] + RF[t], where s = IR[7:4] and t = IR[3:0]. Result is modulo 2^16.
  - 0011 SUB d,s,t: RF[d] ← RF[s] − RF[t]. Result is modulo 2^16.
  - 0101 JMPZ d,off: if RF[d]==0 then PC ← PC_instr + sext(IR[7:0]).
    - Arithmetic is modulo 2^PC_W.
    - PC_instr is the address the JMPZ was fetched from, i.e. PC−1 after FETCH.
  - 1111 HALT.
  - Any other opcode sets illegal=1 and goes to HALT.
- States and transitions:
  - INIT → FETCH.
  - FETCH: I_addr=PC, I_rd=1. At the edge, IR ← I_data and PC ← PC+1, wrapping from 2^PC_W−1 to 0. Next state is DECODE.
  - DECODE: next state by opcode: LOAD, STORE, ADD, SUB, JMPZ, HALT, or ILL→HALT.
  - LOAD: D_addr=IR[7:0], D_rd=1, RF_s=1, RF_W_addr=d, RF_W_wr=1. Next state FETCH.
  - STORE: D_addr=IR[7:0], D_wr=1, RF_Rp_addr=d, RF_Rp_rd=1. Next state FETCH.
  - ADD: RF_Rp_addr=s, RF_Rp_rd=1, RF_Rq_addr=t, RF_Rq_rd=1, RF_W_addr=d, RF_W_wr=1, RF_s=0, alu_s0=0. Next state FETCH.
  - SUB: same as ADD but alu_s0=1. Next state FETCH.
  - JMPZ: RF_Rp_addr=d, RF_Rp_rd=1. If Rp_data==16'h0000, PC ← PC − 1 + sext(off) at the edge. Next state FETCH.
  - HALT: halted=1, I_rd=0, all other strobes 0. Stays in HALT until rst is asserted.
- Latency: every instruction takes 3 cycles (FETCH, DECODE, execute), including a taken or untaken JMPZ. HALT is entered after 2 cycles.
- A JMPZ with off = 0 targets itself: an infinite loop while RF[d]==0, 3 cycles per iteration.
- In ADD/SUB, d may equal s or t. The write occurs at the end of the execute cycle, so the operands read are the old values.

Test Plan:
- Reset/init: hold rst=0 for 3 cycles mid-STORE → D_wr=0 immediately after the first reset edge, PC=0, outputs 0. Release rst → one INIT cycle, then FETCH with I_addr=0, I_rd=1.
- LOAD/ADD/STORE program: ROM = {0000_0001_00000000, 0000_0010_00000001, 0010_0011_0001_0010, 0001_0011_00001001, F000}, D[0]=5, D[1]=7 → D[9]=12 written with D_wr high exactly one cycle. halted=1 at cycle 14 after INIT.
- SUB wrap: R1=0, R2=1, SUB R3,R1,R2 → alu_s0=1 during execute, and STORE R3 writes 16'hFFFF.
- JMPZ taken/untaken: JMPZ at address 4 with off=8'hFE (−2) and RF[d]=0 → next fetch I_addr=2. Same instruction with RF[d]=3 → next fetch I_addr=5.
- PC wrap: ROM word at 255 = ADD → the following fetch has I_addr=0. A JMPZ at 0 with off=−1 and zero operand → next fetch at 255.
- Illegal opcode 0111 → illegal=1, halted=1 two cycles after its FETCH, no RF/DM strobes. Both flags clear only after rst=0.
